// File: rtl/reg_unit_sb.sv
// LC-3 style register file with operand capture and a per-register busy scoreboard.
// Define REGU_BYPASS_EN to forward same-cycle write-back data into waiting sources.
module reg_unit_sb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic                Clk,
  input  logic                Reset_al,
  input  logic [15:0]         IR,
  input  logic                DRMUX,
  input  logic                SR1MUX,
  input  logic                Issue_valid,
  input  logic                Issue_wr,
  output logic                Issue_ready,
  input  logic                WB_valid,
  input  logic [IDX_W-1:0]    WB_DR,
  input  logic [DATA_W-1:0]   WB_Data,
  output logic [DATA_W-1:0]   SR1_out,
  output logic [DATA_W-1:0]   SR2_MUX_out,
  output logic [IDX_W-1:0]    Issue_DR,
  output logic                Op_valid,
  output logic [NUM_REGS-1:0] Busy
);

  function automatic logic signed [DATA_W-1:0] sext_imm5(input logic [4:0] imm);
    logic signed [4:0] imm_s;
    imm_s = $signed(imm);
    return DATA_W'(imm_s);
  endfunction

  function automatic logic [IDX_W-1:0] zext_idx(input logic [2:0] fld);
    return IDX_W'(fld);
  endfunction

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [DATA_W-1:0]   sr1_out_q, sr1_out_d;
  logic [DATA_W-1:0]   sr2_out_q, sr2_out_d;
  logic [IDX_W-1:0]    issue_dr_q, issue_dr_d;
  logic                op_valid_q, op_valid_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  logic [IDX_W-1:0]    dr_idx, sr1_idx, sr2_idx;
  logic                use_imm;
  logic                fwd_sr1, fwd_sr2, fwd_dr;
  logic                h1, h2, hd, issue_ready, accept;
  logic [DATA_W-1:0]   sr1_val, sr2_val;

  logic unused_ir_hi;
  assign unused_ir_hi = ^IR[15:12];

  // Operand decode and hazard detection
  always_comb begin
    dr_idx  = DRMUX ? IDX_W'(NUM_REGS - 1) : zext_idx(IR[11:9]);
    sr1_idx = SR1MUX ? zext_idx(IR[8:6]) : zext_idx(IR[11:9]);
    sr2_idx = zext_idx(IR[2:0]);
    use_imm = IR[5];

`ifdef REGU_BYPASS_EN
    fwd_sr1 = WB_valid && (WB_DR == sr1_idx);
    fwd_sr2 = WB_valid && (WB_DR == sr2_idx);
    fwd_dr  = WB_valid && (WB_DR == dr_idx);
`else
    fwd_sr1 = 1'b0;
    fwd_sr2 = 1'b0;
    fwd_dr  = 1'b0;
`endif

    h1 = busy_q[sr1_idx] && !fwd_sr1;
    h2 = !use_imm && busy_q[sr2_idx] && !fwd_sr2;
    hd = Issue_wr && busy_q[dr_idx] && !fwd_dr;
    issue_ready = !(h1 || h2 || hd);
    accept      = Issue_valid && issue_ready;

    sr1_val = fwd_sr1 ? WB_Data : regs_q[sr1_idx];
    if (use_imm) begin
      sr2_val = sext_imm5(IR[4:0]);
    end else begin
      sr2_val = fwd_sr2 ? WB_Data : regs_q[sr2_idx];
    end
  end

  // Next state: operand capture, register write-back, scoreboard
  always_comb begin
    sr1_out_d  = sr1_out_q;
    sr2_out_d  = sr2_out_q;
    issue_dr_d = issue_dr_q;
    op_valid_d = accept;
    busy_d     = busy_q;
    regs_d     = regs_q;

    if (accept) begin
      sr1_out_d  = sr1_val;
      sr2_out_d  = sr2_val;
      issue_dr_d = dr_idx;
    end

    if (WB_valid) begin
      regs_d[WB_DR] = WB_Data;
      busy_d[WB_DR] = 1'b0;
    end
    // A same-edge issue to the same register re-marks it pending after the clear
    if (accept && Issue_wr) begin
      busy_d[dr_idx] = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      sr1_out_q  <= '0;
      sr2_out_q  <= '0;
      issue_dr_q <= '0;
      op_valid_q <= 1'b0;
      busy_q     <= '0;
    end else begin
      regs_q     <= regs_d;
      sr1_out_q  <= sr1_out_d;
      sr2_out_q  <= sr2_out_d;
      issue_dr_q <= issue_dr_d;
      op_valid_q <= op_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign Issue_ready = issue_ready;
  assign SR1_out     = sr1_out_q;
  assign SR2_MUX_out = sr2_out_q;
  assign Issue_DR    = issue_dr_q;
  assign Op_valid    = op_valid_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_reg_unit_sb.sv
// Directed bench for reg_unit_sb: issued operands go through a scoreboard queue
// checked by a monitor on Op_valid; scoreboard/ready state is checked inline.
module tb_reg_unit_sb;

  logic        Clk = 1'b0;
  logic        Reset_al;
  logic [15:0] IR;
  logic        DRMUX, SR1MUX, Issue_valid, Issue_wr, Issue_ready;
  logic        WB_valid;
  logic [2:0]  WB_DR;
  logic [15:0] WB_Data;
  logic [15:0] SR1_out, SR2_MUX_out;
  logic [2:0]  Issue_DR;
  logic        Op_valid;
  logic [7:0]  Busy;

  reg_unit_sb dut (
    .Clk(Clk), .Reset_al(Reset_al), .IR(IR), .DRMUX(DRMUX), .SR1MUX(SR1MUX),
    .Issue_valid(Issue_valid), .Issue_wr(Issue_wr), .Issue_ready(Issue_ready),
    .WB_valid(WB_valid), .WB_DR(WB_DR), .WB_Data(WB_Data),
    .SR1_out(SR1_out), .SR2_MUX_out(SR2_MUX_out), .Issue_DR(Issue_DR),
    .Op_valid(Op_valid), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] s1;
    logic [15:0] s2;
    logic [2:0]  dr;
  } exp_t;

  exp_t        sb_q [$];
  logic [15:0] mdl [8];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [15:0] s1, input logic [15:0] s2, input logic [2:0] dr);
    exp_t e;
    e.s1 = s1;
    e.s2 = s2;
    e.dr = dr;
    sb_q.push_back(e);
  endtask

  task automatic wb(input logic [2:0] d, input logic [15:0] v);
    WB_valid = 1'b1;
    WB_DR    = d;
    WB_Data  = v;
    tick();
    WB_valid = 1'b0;
    mdl[d]   = v;
  endtask

  task automatic present(input logic [15:0] ir, input logic s1m, input logic dm, input logic wr);
    IR          = ir;
    SR1MUX      = s1m;
    DRMUX       = dm;
    Issue_wr    = wr;
    Issue_valid = 1'b1;
    #1;
  endtask

  // Monitor: every Op_valid pulse must match the oldest expected issue
  always @(negedge Clk) begin
    if (Op_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL op_unexpected: got Op_valid=1 expected no pending issue (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("op_sr1", 32'(SR1_out), 32'(e.s1));
        chk("op_sr2", 32'(SR2_MUX_out), 32'(e.s2));
        chk("op_dr", 32'(Issue_DR), 32'(e.dr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "timeout");
  end

  initial begin
    Reset_al = 1'b0;
    IR = '0; DRMUX = 0; SR1MUX = 0; Issue_valid = 0; Issue_wr = 0;
    WB_valid = 0; WB_DR = '0; WB_Data = '0;
    for (int i = 0; i < 8; i++) mdl[i] = '0;

    #3;
    chk("rst_busy", 32'(Busy), 32'h00);
    chk("rst_opv", 32'(Op_valid), 32'h0);
    chk("rst_sr1", 32'(SR1_out), 32'h0);
    chk("rst_sr2", 32'(SR2_MUX_out), 32'h0);
    chk("rst_dr", 32'(Issue_DR), 32'h0);
    tick();
    Reset_al = 1'b1;

    // 1: first issue after reset
    present(16'h1283, 1'b1, 1'b0, 1'b1);
    chk("t1_ready", 32'(Issue_ready), 32'h1);
    push(16'h0000, 16'h0000, 3'd1);
    tick();
    Issue_valid = 0; Issue_wr = 0;
    chk("t1_busy", 32'(Busy), 32'h02);

    // 2: write-back then read operands
    wb(3'd2, 16'h1234);
    wb(3'd3, 16'h0001);
    wb(3'd1, 16'h5555);
    chk("t2_busy_clr", 32'(Busy), 32'h00);
    present(16'h1283, 1'b1, 1'b0, 1'b0);
    chk("t2_ready", 32'(Issue_ready), 32'h1);
    push(16'h1234, 16'h0001, 3'd1);
    tick();
    Issue_valid = 0;
    tick();
    chk("t2_hold_sr1", 32'(SR1_out), 32'h1234);
    chk("t2_hold_sr2", 32'(SR2_MUX_out), 32'h0001);

    // 3: immediates ignore a busy SR2, register form stalls on it
    present(16'h0600, 1'b1, 1'b0, 1'b1);
    chk("t3_ready_w3", 32'(Issue_ready), 32'h1);
    push(16'h0000, 16'h0000, 3'd3);
    tick();
    chk("t3_busy", 32'(Busy), 32'h08);
    present(16'h1283, 1'b1, 1'b0, 1'b0);
    chk("t3_h2_stall", 32'(Issue_ready), 32'h0);
    tick();
    present(16'h08B3, 1'b1, 1'b0, 1'b0);
    chk("t3_imm_ready", 32'(Issue_ready), 32'h1);
    push(16'h1234, 16'hFFF3, 3'd4);
    tick();
    present(16'h08B0, 1'b1, 1'b0, 1'b0);
    chk("t3_imm16_ready", 32'(Issue_ready), 32'h1);
    push(16'h1234, 16'hFFF0, 3'd4);
    tick();
    Issue_valid = 0;
    wb(3'd3, 16'h0001);
    chk("t3_busy_clr", 32'(Busy), 32'h00);

    // 4: stall on busy SR1, released by write-back
    present(16'h0400, 1'b1, 1'b0, 1'b1);
    chk("t4_ready_w2", 32'(Issue_ready), 32'h1);
    push(16'h0000, 16'h0000, 3'd2);
    tick();
    chk("t4_busy", 32'(Busy), 32'h04);
    present(16'h1283, 1'b1, 1'b0, 1'b1);
    chk("t4_stall", 32'(Issue_ready), 32'h0);
    tick();
    chk("t4_stall_busy", 32'(Busy), 32'h04);
    chk("t4_hold_sr1", 32'(SR1_out), 32'h0000);
    chk("t4_hold_dr", 32'(Issue_DR), 32'd2);
    WB_valid = 1; WB_DR = 3'd2; WB_Data = 16'hBEEF;
    #1;
`ifdef REGU_BYPASS_EN
    chk("t4_wb_ready", 32'(Issue_ready), 32'h1);
    push(16'hBEEF, 16'h0001, 3'd1);
    tick();
    WB_valid = 0; Issue_valid = 0;
    mdl[2] = 16'hBEEF;
`else
    chk("t4_wb_ready", 32'(Issue_ready), 32'h0);
    tick();
    WB_valid = 0;
    mdl[2] = 16'hBEEF;
    #1;
    chk("t4_after_ready", 32'(Issue_ready), 32'h1);
    push(16'hBEEF, 16'h0001, 3'd1);
    tick();
    Issue_valid = 0;
`endif
    chk("t4_busy_after", 32'(Busy), 32'h02);

    // 5: same-edge issue-write and write-back on R1
`ifndef REGU_BYPASS_EN
    wb(3'd1, 16'h1111);
`endif
    WB_valid = 1; WB_DR = 3'd1; WB_Data = 16'h2222;
    present(16'h1283, 1'b1, 1'b0, 1'b1);
    chk("t5_ready", 32'(Issue_ready), 32'h1);
    push(16'hBEEF, 16'h0001, 3'd1);
    tick();
    WB_valid = 0; Issue_valid = 0; Issue_wr = 0;
    mdl[1] = 16'h2222;
    chk("t5_busy_set_wins", 32'(Busy), 32'h02);

    present(16'h1283, 1'b0, 1'b0, 1'b0);
    Issue_valid = 0;
    chk("t5_h1_sr1mux0", 32'(Issue_ready), 32'h0);
    present(16'h1283, 1'b1, 1'b1, 1'b1);
    chk("t5_link_ready", 32'(Issue_ready), 32'h1);
    push(16'hBEEF, 16'h0001, 3'd7);
    tick();
    Issue_valid = 0; DRMUX = 0;
    chk("t5_link_busy", 32'(Busy), 32'h82);

    // 6: fill the scoreboard, then reset asynchronously mid-stall
    for (int k = 0; k < 8; k++) begin
      if (k != 1 && k != 7) begin
        present(16'((k << 9) | 16'h0020), 1'b0, 1'b0, 1'b1);
        chk("t6_fill_ready", 32'(Issue_ready), 32'h1);
        push(mdl[k], 16'h0000, 3'(k));
        tick();
      end
    end
    Issue_valid = 0; Issue_wr = 0;
    chk("t6_busy_full", 32'(Busy), 32'hFF);
    tick();
    present(16'h1283, 1'b1, 1'b0, 1'b0);
    chk("t6_stall", 32'(Issue_ready), 32'h0);
    #1;
    Reset_al = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(Busy), 32'h00);
    chk("t6_rst_sr1", 32'(SR1_out), 32'h0);
    chk("t6_rst_sr2", 32'(SR2_MUX_out), 32'h0);
    chk("t6_rst_dr", 32'(Issue_DR), 32'h0);
    chk("t6_rst_opv", 32'(Op_valid), 32'h0);
    chk("t6_rst_ready", 32'(Issue_ready), 32'h1);
    Issue_valid = 0;
    tick();
    Reset_al = 1'b1;
    for (int i = 0; i < 8; i++) mdl[i] = '0;

    present(16'h1283, 1'b1, 1'b0, 1'b0);
    chk("t6_post_ready", 32'(Issue_ready), 32'h1);
    push(16'h0000, 16'h0000, 3'd1);
    tick();
    Issue_valid = 0;
    tick();
    tick();
    chk("sb_drain", 32'(sb_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_unit_sb.md
Name: reg_unit_sb

Overview:
Parametrised successor to the LC-3 register unit for the pipelined datapath. It holds the general-purpose register file and does the DR/SR1/SR2 operand selection from IR. It captures the selected operands into output registers on issue, and tracks pending writes with a per-register busy scoreboard. The block sits between decode (issue handshake) and execute, and takes write-back from the end of the pipeline.

Parameters:
DATA_W, 16, register and operand width; must be at least 5.
NUM_REGS, 8, number of registers; power of 2, at least 8. IDX_W = log2(NUM_REGS) is derived.

Ports:
Clk  in  1  system clock, rising edge
Reset_al  in  1  asynchronous, active-low reset
IR  in  16  instruction presented for issue
DRMUX  in  1  0: DR = IR[11:9]; 1: DR = NUM_REGS-1 (link register)
SR1MUX  in  1  0: SR1 = IR[11:9]; 1: SR1 = IR[8:6]
Issue_valid  in  1  decode presents an instruction
Issue_wr  in  1  the issued instruction will write DR
Issue_ready  out  1  operands available; issue accepted when Issue_valid && Issue_ready
WB_valid  in  1  write-back strobe
WB_DR  in  IDX_W  write-back destination
WB_Data  in  DATA_W  write-back value
SR1_out  out  DATA_W  registered SR1 operand
SR2_MUX_out  out  DATA_W  registered SR2 operand, or sign-extended immediate
Issue_DR  out  IDX_W  registered DR of the last accepted issue
Op_valid  out  1  one-cycle pulse: operands valid
Busy  out  NUM_REGS  scoreboard, bit i set means a write to Ri is pending

Behaviour:
- Reset (Reset_al low, asynchronous): all registers 0, Busy 0, SR1_out/SR2_MUX_out 0, Issue_DR 0, Op_valid 0. A reset mid-operation discards all pending writes.
- Register indices: IR fields are zero-extended to IDX_W.
  - SR2 = IR[2:0].
  - IR[5]=1 selects the immediate: sign-extend IR[4:0] to DATA_W, e.g. 5'b10000 -> all ones except the low 4 bits are 0 (0xFFF0 at width 16).
- Hazard terms (combinational):
  - h1 = Busy[SR1].
  - h2 = (IR[5]==0) && Busy[SR2].
  - hd = Issue_wr && Busy[DR].
  - Issue_ready = !(h1 || h2 || hd).
  - Issue_ready does not depend on Issue_valid.
- Issue (rising edge, Issue_valid && Issue_ready):
  - SR1_out, SR2_MUX_out and Issue_DR are loaded.
  - Op_valid = 1 the next cycle, for exactly one cycle.
  - Busy[DR] is set if Issue_wr.
  - Latency: 1 cycle from accept to Op_valid.
- No issue: Op_valid = 0; SR1_out, SR2_MUX_out and Issue_DR hold their values.
- Write-back (rising edge, WB_valid):
  - reg[WB_DR] <= WB_Data; Busy[WB_DR] is cleared.
  - A write-back to a non-busy register still writes and leaves Busy at 0.
- Same-edge issue and write-back on the same register index: the issue's set of Busy wins over the write-back's clear.
- Read values reflect writes committed at earlier edges only, unless the optional bypass is compiled in.
- No state machine beyond the scoreboard; throughput is 1 issue per cycle when there are no hazards.

Optional Feature:
REGU_BYPASS_EN
- Defined: a source hazard is waived when WB_valid && WB_DR == that source index.
  - The operand is taken from WB_Data in the same cycle, not from the array.
  - hd is likewise waived when WB_DR == DR.
- Undefined: no forwarding; issue stalls until the cycle after the write-back.

Test Plan:
1. Reset, then issue ADD with IR=0x1283 (DR=R1, SR1=R2, SR2=R3) and Issue_wr=1 -> Issue_ready=1; next cycle Op_valid=1, SR1_out=0, SR2_MUX_out=0, Issue_DR=1, Busy=0x02.
2. WB R2=0x1234 and R3=0x0001, then issue 0x1283 -> SR1_out=0x1234, SR2_MUX_out=0x0001.
3. Issue an immediate with IR[5]=1, IR[4:0]=5'b10000 -> SR2_MUX_out=0xFFF0; Busy[SR2] is ignored.
4. Busy[R2] set, IR=0x1283 presented -> Issue_ready=0; Op_valid stays 0; outputs hold.
   - Then WB_valid, WB_DR=2, WB_Data=0xBEEF:
     - with bypass: accepted that cycle, SR1_out=0xBEEF;
     - without bypass: Issue_ready=0 in the WB cycle, accepted 1 cycle later, SR1_out=0xBEEF.
5. Issue a write to R1 in the same cycle as a WB to R1 (R1 already busy, bypass on) -> Busy[1] remains 1.
6. Assert Reset_al low mid-stall with Busy=0xFF -> Busy=0, all outputs 0 immediately, without waiting for a clock edge.
